// File: rtl/nnrv_mmio_pkg.sv
// Shared definitions for MMIO responders on the core's RAM-style port.
// Holds the timer register map, CTRL bit positions and the byte-lane merge helper.
package nnrv_mmio_pkg;

    typedef enum logic [2:0] {
        MMIO_TMR_MTIME_LO    = 3'd0,
        MMIO_TMR_MTIME_HI    = 3'd1,
        MMIO_TMR_MTIMECMP_LO = 3'd2,
        MMIO_TMR_MTIMECMP_HI = 3'd3,
        MMIO_TMR_CTRL        = 3'd4,
        MMIO_TMR_STATUS      = 3'd5,
        MMIO_TMR_PRESCALE    = 3'd6,
        MMIO_TMR_RSVD        = 3'd7
    } mmio_tmr_reg_e;

    localparam int unsigned CTRL_EN_BIT     = 0;
    localparam int unsigned CTRL_IRQ_EN_BIT = 1;

    localparam logic [63:0] MMIO_TMR_MTIMECMP_RST = '1;

    // Byte n of the result comes from new_word when mask[n] is set, else from old_word.
    function automatic logic [31:0] mmio_byte_merge(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  mask
    );
        logic [31:0] merged;
        merged = old_word;
        for (int unsigned i = 0; i < 4; i++) begin
            if (mask[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/nnrv_tmr_prescaler.sv
// Timer prescaler: counts cycles while enabled and emits a one-cycle tick
// when the count matches PRESCALE; a PRESCALE write restarts the count.
module nnrv_tmr_prescaler (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_en,
    input  logic [15:0] i_prescale,
    input  logic        i_clear,
    output logic        o_tick
);

    logic [15:0] pcnt;

    assign o_tick = i_en && (pcnt == i_prescale);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pcnt <= '0;
        end else if (i_clear) begin
            pcnt <= '0;
        end else if (i_en) begin
            pcnt <= o_tick ? '0 : pcnt + 16'd1;
        end
    end

endmodule

// File: rtl/nnrv_mmio_timer.sv
// Memory-mapped 64-bit timer with compare, sticky pending flag and level IRQ.
// Read data is registered one cycle after the request, matching the RAM timing.
module nnrv_mmio_timer
    import nnrv_mmio_pkg::*;
#(
    parameter int unsigned              ADDR_WIDTH = 8,
    parameter int unsigned              XLEN       = 32,
    parameter logic [ADDR_WIDTH-1:0]    BASE_ADDR  = 8'hE0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    input  logic                  i_rd_en,
    input  logic [3:0]            i_rd_mask,
    output logic [XLEN-1:0]       o_rd_data,
    output logic                  o_rd_hit,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic                  i_wr_en,
    input  logic [3:0]            i_wr_mask,
    input  logic [XLEN-1:0]       i_wr_data,
    output logic                  o_irq
);

    logic [63:0]   mtime, mtime_nxt;
    logic [63:0]   mtimecmp, cmp_nxt;
    logic [1:0]    ctrl, ctrl_nxt;
    logic          pend, pend_nxt, pend_clr, irq_nxt;
    logic [15:0]   prescale, prescale_nxt;
    logic          ps_wr, tick, cmp_cond;
    logic          rd_sel, wr_act;
    logic [31:0]   rd_word, ctrl_m, ps_m;
    mmio_tmr_reg_e rd_off, wr_off;
    logic          unused_bits;

    assign rd_sel = i_rd_en && (i_rd_addr[ADDR_WIDTH-1:5] == BASE_ADDR[ADDR_WIDTH-1:5]);
    assign wr_act = i_wr_en && (i_wr_addr[ADDR_WIDTH-1:5] == BASE_ADDR[ADDR_WIDTH-1:5])
                    && (|i_wr_mask);
    assign rd_off = mmio_tmr_reg_e'(i_rd_addr[4:2]);
    assign wr_off = mmio_tmr_reg_e'(i_wr_addr[4:2]);

    assign ctrl_m = mmio_byte_merge({30'd0, ctrl}, i_wr_data, i_wr_mask);
    assign ps_m   = mmio_byte_merge({16'd0, prescale}, i_wr_data, i_wr_mask);

    assign unused_bits = ^{i_rd_addr[1:0], i_wr_addr[1:0], ctrl_m[31:2], ps_m[31:16]};

    assign cmp_cond = ctrl[CTRL_EN_BIT] && (mtime >= mtimecmp);

    nnrv_tmr_prescaler u_prescaler (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_en       (ctrl[CTRL_EN_BIT]),
        .i_prescale (prescale),
        .i_clear    (ps_wr),
        .o_tick     (tick)
    );

    always_comb begin
        rd_word = '0;
        case (rd_off)
            MMIO_TMR_MTIME_LO:    rd_word = mtime[31:0];
            MMIO_TMR_MTIME_HI:    rd_word = mtime[63:32];
            MMIO_TMR_MTIMECMP_LO: rd_word = mtimecmp[31:0];
            MMIO_TMR_MTIMECMP_HI: rd_word = mtimecmp[63:32];
            MMIO_TMR_CTRL:        rd_word = {30'd0, ctrl};
            MMIO_TMR_STATUS:      rd_word = {31'd0, pend};
            MMIO_TMR_PRESCALE:    rd_word = {16'd0, prescale};
            default:              rd_word = '0;
        endcase
    end

    // A write to either mtime half replaces the tick increment for the whole 64-bit value.
    always_comb begin
        mtime_nxt    = tick ? mtime + 64'd1 : mtime;
        cmp_nxt      = mtimecmp;
        ctrl_nxt     = ctrl;
        prescale_nxt = prescale;
        ps_wr        = 1'b0;
        pend_clr     = 1'b0;
        if (wr_act) begin
            case (wr_off)
                MMIO_TMR_MTIME_LO:
                    mtime_nxt = {mtime[63:32], mmio_byte_merge(mtime[31:0], i_wr_data, i_wr_mask)};
                MMIO_TMR_MTIME_HI:
                    mtime_nxt = {mmio_byte_merge(mtime[63:32], i_wr_data, i_wr_mask), mtime[31:0]};
                MMIO_TMR_MTIMECMP_LO:
                    cmp_nxt = {mtimecmp[63:32], mmio_byte_merge(mtimecmp[31:0], i_wr_data, i_wr_mask)};
                MMIO_TMR_MTIMECMP_HI:
                    cmp_nxt = {mmio_byte_merge(mtimecmp[63:32], i_wr_data, i_wr_mask), mtimecmp[31:0]};
                MMIO_TMR_CTRL:
                    ctrl_nxt = ctrl_m[1:0];
                MMIO_TMR_STATUS:
                    pend_clr = i_wr_mask[0] & i_wr_data[0];
                MMIO_TMR_PRESCALE: begin
                    prescale_nxt = ps_m[15:0];
                    ps_wr        = 1'b1;
                end
                default: ;
            endcase
        end
        pend_nxt = cmp_cond | (pend & ~pend_clr);
        irq_nxt  = pend_nxt & ctrl_nxt[CTRL_IRQ_EN_BIT];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mtime     <= '0;
            mtimecmp  <= MMIO_TMR_MTIMECMP_RST;
            ctrl      <= '0;
            pend      <= 1'b0;
            prescale  <= '0;
            o_irq     <= 1'b0;
            o_rd_data <= '0;
            o_rd_hit  <= 1'b0;
        end else begin
            mtime     <= mtime_nxt;
            mtimecmp  <= cmp_nxt;
            ctrl      <= ctrl_nxt;
            pend      <= pend_nxt;
            prescale  <= prescale_nxt;
            o_irq     <= irq_nxt;
            o_rd_data <= rd_sel ? mmio_byte_merge('0, rd_word, i_rd_mask) : '0;
            o_rd_hit  <= rd_sel;
        end
    end

endmodule

// File: tb/tb_nnrv_mmio_timer.sv
// Directed self-checking bench for nnrv_mmio_timer; expected values are
// worked out by hand from the register map and prescaler timing.
module tb_nnrv_mmio_timer;

    logic        clk;
    logic        rst;
    logic [7:0]  rd_addr;
    logic        rd_en;
    logic [3:0]  rd_mask;
    logic [31:0] rd_data;
    logic        rd_hit;
    logic [7:0]  wr_addr;
    logic        wr_en;
    logic [3:0]  wr_mask;
    logic [31:0] wr_data;
    logic        irq;

    int checks = 0;
    int errors = 0;

    localparam logic [7:0] A_MTIME_LO = 8'hE0;
    localparam logic [7:0] A_MTIME_HI = 8'hE4;
    localparam logic [7:0] A_CMP_LO   = 8'hE8;
    localparam logic [7:0] A_CMP_HI   = 8'hEC;
    localparam logic [7:0] A_CTRL     = 8'hF0;
    localparam logic [7:0] A_STATUS   = 8'hF4;
    localparam logic [7:0] A_PRESCALE = 8'hF8;
    localparam logic [7:0] A_RSVD     = 8'hFC;

    nnrv_mmio_timer #(
        .ADDR_WIDTH (8),
        .XLEN       (32),
        .BASE_ADDR  (8'hE0)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_rd_addr (rd_addr),
        .i_rd_en   (rd_en),
        .i_rd_mask (rd_mask),
        .o_rd_data (rd_data),
        .o_rd_hit  (rd_hit),
        .i_wr_addr (wr_addr),
        .i_wr_en   (wr_en),
        .i_wr_mask (wr_mask),
        .i_wr_data (wr_data),
        .o_irq     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_read(input logic [7:0] addr, input logic [3:0] mask,
                           input logic [31:0] exp_data, input logic exp_hit, input string tag);
        rd_addr = addr;
        rd_mask = mask;
        rd_en   = 1'b1;
        step(1);
        rd_en   = 1'b0;
        check({tag, "_data"}, rd_data, exp_data);
        check({tag, "_hit"}, {31'd0, rd_hit}, {31'd0, exp_hit});
    endtask

    task automatic do_write(input logic [7:0] addr, input logic [3:0] mask, input logic [31:0] data);
        wr_addr = addr;
        wr_mask = mask;
        wr_data = data;
        wr_en   = 1'b1;
        step(1);
        wr_en   = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        rd_addr = '0; rd_en = 1'b0; rd_mask = '0;
        wr_addr = '0; wr_en = 1'b0; wr_mask = '0; wr_data = '0;
        step(2);
        rst = 1'b0;
        check("rst_rd_data", rd_data, 32'h0);
        check("rst_rd_hit", {31'd0, rd_hit}, 32'h0);
        check("rst_irq", {31'd0, irq}, 32'h0);

        do_read(A_MTIME_LO, 4'hF, 32'h0, 1'b1, "rv_mtime_lo");
        do_read(A_MTIME_HI, 4'hF, 32'h0, 1'b1, "rv_mtime_hi");
        do_read(A_CMP_LO,   4'hF, 32'hFFFF_FFFF, 1'b1, "rv_cmp_lo");
        do_read(A_CMP_HI,   4'hF, 32'hFFFF_FFFF, 1'b1, "rv_cmp_hi");
        do_read(A_CTRL,     4'hF, 32'h0, 1'b1, "rv_ctrl");
        do_read(A_STATUS,   4'hF, 32'h0, 1'b1, "rv_status");
        do_read(A_PRESCALE, 4'hF, 32'h0, 1'b1, "rv_prescale");
        step(1);
        check("hit_one_cycle", {31'd0, rd_hit}, 32'h0);

        // Prescale 3: ticks on every 4th edge after enabling, so 5 in 20 edges.
        do_write(A_PRESCALE, 4'hF, 32'h0000_0003);
        do_read(A_PRESCALE, 4'hF, 32'h3, 1'b1, "prescale_rd");
        do_write(A_CTRL, 4'hF, 32'h1);
        step(20);
        do_read(A_MTIME_LO, 4'hF, 32'd5, 1'b1, "ps3_mtime");
        do_write(A_PRESCALE, 4'hF, 32'h0);
        do_read(A_MTIME_LO, 4'hF, 32'd5, 1'b1, "ps0_mtime_a");
        do_read(A_MTIME_LO, 4'hF, 32'd6, 1'b1, "ps0_mtime_b");

        // 32-bit carry into the high half, then a byte write that suppresses a tick.
        do_write(A_CTRL, 4'hF, 32'h0);
        do_write(A_MTIME_LO, 4'hF, 32'hFFFF_FFFF);
        do_write(A_MTIME_HI, 4'hF, 32'h0);
        do_write(A_CTRL, 4'hF, 32'h1);
        do_write(A_CTRL, 4'hF, 32'h0);
        do_read(A_MTIME_HI, 4'hF, 32'h1, 1'b1, "carry_hi");
        do_read(A_MTIME_LO, 4'hF, 32'h0, 1'b1, "carry_lo");
        do_write(A_CTRL, 4'hF, 32'h1);
        do_write(A_MTIME_LO, 4'b0010, 32'h0000_AB00);
        do_write(A_CTRL, 4'hF, 32'h0);
        do_read(A_MTIME_LO, 4'hF, 32'h0000_AB01, 1'b1, "bytewr_lo");
        do_read(A_MTIME_HI, 4'hF, 32'h1, 1'b1, "bytewr_hi");

        // Compare at 10 with IRQ enabled.
        do_write(A_MTIME_LO, 4'hF, 32'h0);
        do_write(A_MTIME_HI, 4'hF, 32'h0);
        do_write(A_CMP_LO, 4'hF, 32'd10);
        do_write(A_CMP_HI, 4'hF, 32'h0);
        do_write(A_CTRL, 4'hF, 32'h3);
        step(10);
        check("irq_before_cmp", {31'd0, irq}, 32'h0);
        step(1);
        check("irq_at_cmp", {31'd0, irq}, 32'h1);
        do_read(A_STATUS, 4'hF, 32'h1, 1'b1, "pend_set");
        do_write(A_STATUS, 4'hF, 32'h1);
        check("w1c_set_wins_irq", {31'd0, irq}, 32'h1);
        do_read(A_STATUS, 4'hF, 32'h1, 1'b1, "w1c_set_wins");
        do_write(A_CMP_LO, 4'hF, 32'd1000);
        do_write(A_STATUS, 4'hF, 32'h1);
        check("w1c_clear_irq", {31'd0, irq}, 32'h0);
        do_read(A_STATUS, 4'hF, 32'h0, 1'b1, "w1c_clear");

        // IRQ_EN=0: PEND sets at mtime 20 but the line stays low.
        do_write(A_CTRL, 4'hF, 32'h1);
        do_write(A_CMP_LO, 4'hF, 32'd20);
        step(5);
        check("irq_masked", {31'd0, irq}, 32'h0);
        do_read(A_STATUS, 4'hF, 32'h1, 1'b1, "masked_pend");
        do_read(A_CTRL, 4'hF, 32'h1, 1'b1, "ctrl_rd");

        // Read masking, misses, reserved slot and no-op writes.
        do_write(A_CMP_LO, 4'hF, 32'h1122_3344);
        do_read(A_CMP_LO, 4'b0100, 32'h0022_0000, 1'b1, "rd_mask");
        do_read(8'h28, 4'hF, 32'h0, 1'b0, "rd_miss");
        do_read(A_RSVD, 4'hF, 32'h0, 1'b1, "rd_rsvd");
        do_write(8'h08, 4'hF, 32'h0);
        do_write(A_CMP_LO, 4'h0, 32'h0);
        do_read(A_CMP_LO, 4'hF, 32'h1122_3344, 1'b1, "noop_writes");

        // Reset in the middle of a read with the timer running and IRQ high.
        do_write(A_CTRL, 4'hF, 32'h3);
        check("irq_before_rst", {31'd0, irq}, 32'h1);
        rd_addr = A_CTRL;
        rd_mask = 4'hF;
        rd_en   = 1'b1;
        rst     = 1'b1;
        step(1);
        rd_en   = 1'b0;
        rst     = 1'b0;
        check("midrst_hit", {31'd0, rd_hit}, 32'h0);
        check("midrst_data", rd_data, 32'h0);
        check("midrst_irq", {31'd0, irq}, 32'h0);
        do_read(A_MTIME_LO, 4'hF, 32'h0, 1'b1, "midrst_mtime");
        do_read(A_CMP_HI, 4'hF, 32'hFFFF_FFFF, 1'b1, "midrst_cmp");
        do_read(A_CTRL, 4'hF, 32'h0, 1'b1, "midrst_ctrl");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
